// File: rtl/vga_pkg.sv
// Shared VGA constants, pipeline types and the built-in sprite image.
package vga_pkg;

  localparam int DISPLAY_H = 640;
  localparam int DISPLAY_V = 480;
  localparam int RGB_W     = 12;
  localparam int COORD_W   = 10;

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [COORD_W-1:0] coord_t;

  // Built-in 16x16 sprite: anti-diagonal texels carry the F0F colour key.
  function automatic rgb_t sprite_image(input logic [7:0] a);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = a[7:4];
    lo = a[3:0];
    if (lo == ~hi) begin
      return 12'hF0F;
    end
    return {hi, lo, ~(hi ^ lo)};
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM with a registered read port, one clk of latency.
module sprite_rom
  import vga_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output rgb_t          q
);

  always_ff @(posedge clk) begin
    q <= sprite_image(8'(addr));
  end

endmodule

// File: rtl/vga_sprite_pixel.sv
// Pixel stage after vga_sync: overlays a colour-keyed ROM sprite on a background,
// with tear-free position updates committed at frame start.
module vga_sprite_pixel
  import vga_pkg::*;
#(
  parameter int   SPR_W   = 16,
  parameter int   SPR_H   = 16,
  parameter rgb_t KEY_RGB = 12'hF0F,
  parameter int   RST_X   = 0,
  parameter int   RST_Y   = 0,
  parameter int   AW      = 8
) (
  input  logic   clk,
  input  logic   clr_n,
  input  logic   p_tick,
  input  logic   f_tick,
  input  logic   video_on,
  input  logic   hsync_in,
  input  logic   vsync_in,
  input  coord_t x,
  input  coord_t y,
  input  rgb_t   bg_rgb,
  input  logic   pos_valid,
  input  coord_t pos_x,
  input  coord_t pos_y,
  output logic   pos_ready,
  output rgb_t   rgb,
  output logic   hsync,
  output logic   vsync,
  output logic   hit
);

  localparam logic [10:0] W11 = 11'(SPR_W);
  localparam logic [10:0] H11 = 11'(SPR_H);
  localparam coord_t      RX  = coord_t'(RST_X);
  localparam coord_t      RY  = coord_t'(RST_Y);

  coord_t ax_reg, ay_reg, px_reg, py_reg;
  coord_t ax_next, ay_next, px_next, py_next;
  logic   pending_reg, pending_next;

  // Commit wins over accept; the two can never collide because ready is low while pending.
  always_comb begin
    ax_next      = ax_reg;
    ay_next      = ay_reg;
    px_next      = px_reg;
    py_next      = py_reg;
    pending_next = pending_reg;
    if (p_tick && f_tick && pending_reg) begin
      ax_next      = px_reg;
      ay_next      = py_reg;
      pending_next = 1'b0;
    end else if (pos_valid && !pending_reg) begin
      px_next      = pos_x;
      py_next      = pos_y;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ax_reg      <= RX;
      ay_reg      <= RY;
      px_reg      <= RX;
      py_reg      <= RY;
      pending_reg <= 1'b0;
    end else begin
      ax_reg      <= ax_next;
      ay_reg      <= ay_next;
      px_reg      <= px_next;
      py_reg      <= py_next;
      pending_reg <= pending_next;
    end
  end

  assign pos_ready = !pending_reg;

  // Stage 1: box test and ROM address, 11-bit so ax+SPR_W cannot wrap.
  logic [10:0]   x11, y11, ax11, ay11, dx, dy;
  logic          in_box_next;
  logic [AW-1:0] addr_next;

  always_comb begin
    x11         = {1'b0, x};
    y11         = {1'b0, y};
    ax11        = {1'b0, ax_reg};
    ay11        = {1'b0, ay_reg};
    dx          = x11 - ax11;
    dy          = y11 - ay11;
    in_box_next = (x11 >= ax11) && (x11 < ax11 + W11) &&
                  (y11 >= ay11) && (y11 < ay11 + H11);
    addr_next   = AW'(dy) * AW'(SPR_W) + AW'(dx);
  end

  logic [AW-1:0] addr_reg;
  logic          in_box1_reg, von1_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      addr_reg    <= '0;
      in_box1_reg <= 1'b0;
      von1_reg    <= 1'b0;
    end else if (p_tick) begin
      addr_reg    <= addr_next;
      in_box1_reg <= in_box_next;
      von1_reg    <= video_on;
    end
  end

  rgb_t rom_q;

  sprite_rom #(
    .AW (AW)
  ) u_rom (
    .clk  (clk),
    .addr (addr_reg),
    .q    (rom_q)
  );

  // Syncs ride a two-stage delay matching the colour path.
  logic [1:0] sync_in, sync_out;
  assign sync_in = {vsync_in, hsync_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg, s2_reg;
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else if (p_tick) begin
          s1_reg <= sync_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  assign hsync = sync_out[0];
  assign vsync = sync_out[1];

  // Stage 2: colour select; bg_rgb is taken live at this stage.
  logic hit_next;
  rgb_t rgb_next;

  always_comb begin
    hit_next = von1_reg && in_box1_reg && (rom_q != KEY_RGB);
    rgb_next = '0;
    if (von1_reg) begin
      rgb_next = hit_next ? rom_q : bg_rgb;
    end
  end

  rgb_t rgb_reg;
  logic hit_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rgb_reg <= '0;
      hit_reg <= 1'b0;
    end else if (p_tick) begin
      rgb_reg <= rgb_next;
      hit_reg <= hit_next;
    end
  end

  assign rgb = rgb_reg;
  assign hit = hit_reg;

endmodule

// File: tb/tb_vga_sprite_pixel.sv
// Bench for vga_sprite_pixel: directed table, handshake/commit sequences, edge clipping,
// sync delay, mid-line reset and random pixels against a behavioural model.
module tb_vga_sprite_pixel;

  localparam logic [11:0] KEY = 12'hF0F;

  logic       clk = 1'b0;
  logic       clr_n, p_tick, f_tick, video_on, hsync_in, vsync_in;
  logic [9:0] x, y, pos_x, pos_y;
  logic [11:0] bg_rgb, rgb;
  logic       pos_valid, pos_ready, hsync, vsync, hit;

  always #5 clk = ~clk;

  vga_sprite_pixel #(
    .SPR_W   (16),
    .SPR_H   (16),
    .KEY_RGB (12'hF0F),
    .RST_X   (0),
    .RST_Y   (0),
    .AW      (8)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .p_tick    (p_tick),
    .f_tick    (f_tick),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .x         (x),
    .y         (y),
    .bg_rgb    (bg_rgb),
    .pos_valid (pos_valid),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .pos_ready (pos_ready),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .hit       (hit)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hit;
    logic        hs;
    logic        vs;
  } out_t;

  typedef struct {
    int          x;
    int          y;
    bit          von;
    bit          hs;
    bit          vs;
    logic [11:0] bg;
    out_t        e;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: active/pending positions and the pixel captured one tick ago.
  int          ax_m, ay_m, px_m, py_m;
  bit          pend_m;
  bit          m_von, m_in, m_hs, m_vs;
  logic [11:0] m_word;

  // Sprite texel by address: anti-diagonal texels are transparent.
  function automatic logic [11:0] img(input int a);
    int hi, lo;
    hi = a / 16;
    lo = a % 16;
    if (hi + lo == 15) return KEY;
    return 12'(hi * 256 + lo * 16 + (15 - (hi ^ lo)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input out_t e);
    chk({tag, ".rgb"}, 32'(rgb), 32'(e.rgb));
    chk({tag, ".hit"}, 32'(hit), 32'(e.hit));
    chk({tag, ".hsync"}, 32'(hsync), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vsync), 32'(e.vs));
    chk({tag, ".pos_ready"}, 32'(pos_ready), 32'(!pend_m));
  endtask

  task automatic model_reset();
    ax_m = 0; ay_m = 0; px_m = 0; py_m = 0; pend_m = 1'b0;
    m_von = 1'b0; m_in = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_word = '0;
  endtask

  // One pixel tick: p_tick for one clk, then three idle clks.
  task automatic tick(input int tx, input int ty, input bit tvon, input bit ths, input bit tvs,
                      input logic [11:0] tbg, input bit tft, input bit tpv, input int tpx,
                      input int tpy, input bit use_tbl, input out_t te);
    out_t e;
    @(negedge clk);
    x = 10'(tx); y = 10'(ty); video_on = tvon; hsync_in = ths; vsync_in = tvs;
    bg_rgb = tbg; f_tick = tft; pos_valid = tpv; pos_x = 10'(tpx); pos_y = 10'(tpy);
    p_tick = 1'b1;
    e.hit = m_von && m_in && (m_word != KEY);
    e.rgb = !m_von ? 12'h000 : (e.hit ? m_word : tbg);
    e.hs  = m_hs;
    e.vs  = m_vs;
    m_von  = tvon;
    m_hs   = ths;
    m_vs   = tvs;
    m_in   = (tx >= ax_m) && (tx < ax_m + 16) && (ty >= ay_m) && (ty < ay_m + 16);
    m_word = m_in ? img((ty - ay_m) * 16 + (tx - ax_m)) : 12'h000;
    if (pend_m && tft) begin
      ax_m = px_m; ay_m = py_m; pend_m = 1'b0;
    end else if (tpv && !pend_m) begin
      px_m = tpx; py_m = tpy; pend_m = 1'b1;
    end
    @(negedge clk);
    p_tick = 1'b0; f_tick = 1'b0; pos_valid = 1'b0;
    if (use_tbl) e = te;
    check_outs("pix", e);
    repeat (3) @(negedge clk);
    check_outs("hold", e);
  endtask

  task automatic px(input int tx, input int ty, input bit tvon, input logic [11:0] tbg,
                    input bit tft);
    out_t z;
    z = '{12'h000, 1'b0, 1'b0, 1'b0};
    tick(tx, ty, tvon, 1'b0, 1'b0, tbg, tft, 1'b0, 0, 0, 1'b0, z);
  endtask

  task automatic offer(input int tpx, input int tpy);
    @(negedge clk);
    chk("ready_pre", 32'(pos_ready), 32'(!pend_m));
    pos_valid = 1'b1; pos_x = 10'(tpx); pos_y = 10'(tpy);
    if (!pend_m) begin
      px_m = tpx; py_m = tpy; pend_m = 1'b1;
    end
    @(negedge clk);
    pos_valid = 1'b0;
    chk("ready_post", 32'(pos_ready), 32'(!pend_m));
  endtask

  vec_t tbl[9];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t z;
    int   hs_cnt;
    z = '{12'h000, 1'b0, 1'b0, 1'b0};

    // Rows: pixel in, and the output expected after that tick (previous pixel, this row's bg).
    tbl[0] = '{0,  0,  1'b0, 1'b1, 1'b0, 12'h123, '{12'h000, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{0,  0,  1'b1, 1'b0, 1'b1, 12'h123, '{12'h000, 1'b0, 1'b1, 1'b0}};
    tbl[2] = '{5,  0,  1'b1, 1'b0, 1'b0, 12'h123, '{12'h00F, 1'b1, 1'b0, 1'b1}};
    tbl[3] = '{15, 15, 1'b1, 1'b0, 1'b0, 12'h123, '{12'h05A, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{16, 0,  1'b1, 1'b0, 1'b0, 12'h456, '{12'hFFF, 1'b1, 1'b0, 1'b0}};
    tbl[5] = '{15, 0,  1'b1, 1'b0, 1'b0, 12'h456, '{12'h456, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{0,  16, 1'b1, 1'b1, 1'b1, 12'h00F, '{12'h00F, 1'b0, 1'b0, 1'b0}};
    tbl[7] = '{3,  2,  1'b0, 1'b0, 1'b0, 12'h789, '{12'h789, 1'b0, 1'b1, 1'b1}};
    tbl[8] = '{0,  0,  1'b0, 1'b0, 1'b0, 12'h789, '{12'h000, 1'b0, 1'b0, 1'b0}};

    clr_n = 1'b0; p_tick = 1'b0; f_tick = 1'b0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; x = '0; y = '0; bg_rgb = '0;
    pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    model_reset();
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    check_outs("reset", z);

    foreach (tbl[i])
      tick(tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].hs, tbl[i].vs, tbl[i].bg,
           1'b0, 1'b0, 0, 0, 1'b1, tbl[i].e);

    // Position taken mid-frame is not shown until the next frame start.
    offer(100, 50);
    chk("ready_low_pending", 32'(pos_ready), 32'(0));
    px(100, 50, 1'b1, 12'h0A0, 1'b0);
    px(0, 0, 1'b0, 12'h0A0, 1'b0);
    chk("not_shown_yet", 32'(hit), 32'(0));
    px(0, 0, 1'b0, 12'h0A0, 1'b1);
    chk("ready_after_commit", 32'(pos_ready), 32'(1));
    px(100, 50, 1'b1, 12'h0A0, 1'b0);
    px(115, 65, 1'b1, 12'h0A0, 1'b0);
    chk("rom_first", 32'(rgb), 32'(12'h00F));
    px(0, 0, 1'b0, 12'h0A0, 1'b0);
    chk("rom_last", 32'(rgb), 32'(12'hFFF));

    // Accept in the same clk as a frame start with nothing pending waits a frame.
    tick(0, 0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b1, 1'b1, 200, 100, 1'b0, z);
    chk("commit_clk_accept", 32'(pos_ready), 32'(0));
    px(200, 100, 1'b1, 12'h111, 1'b0);
    px(0, 0, 1'b0, 12'h111, 1'b0);
    chk("held_until_next", 32'(hit), 32'(0));
    px(0, 0, 1'b0, 12'h111, 1'b1);
    px(200, 100, 1'b1, 12'h111, 1'b0);
    px(0, 0, 1'b0, 12'h111, 1'b0);
    chk("shown_next_frame", 32'(hit), 32'(1));

    // Sprite hanging off the bottom-right corner is clipped, never wrapped.
    offer(630, 470);
    px(0, 0, 1'b0, 12'h222, 1'b1);
    for (int xx = 626; xx < 648; xx++) px(xx, 470, xx < 640, 12'h222, 1'b0);
    for (int xx = 630; xx < 642; xx++) px(xx, 479, xx < 640, 12'h222, 1'b0);
    for (int xx = 0; xx < 6; xx++) px(xx, 470, 1'b1, 12'h222, 1'b0);
    for (int xx = 0; xx < 6; xx++) begin
      px(xx, 0, 1'b1, 12'h222, 1'b0);
      chk("no_wrap", 32'(hit), 32'(0));
    end

    // 96-tick hsync pulse keeps its width through the pipeline.
    hs_cnt = 0;
    for (int k = 0; k < 110; k++) begin
      tick(0, 0, 1'b0, (k >= 2 && k < 98), 1'b0, 12'h333, 1'b0, 1'b0, 0, 0, 1'b0, z);
      if (hsync) hs_cnt++;
    end
    chk("hsync_width", 32'(hs_cnt), 32'(96));

    // Random pixels, frame starts and position offers.
    for (int k = 0; k < 400; k++) begin
      int  rx, ry;
      bit  ft, pv;
      if ($urandom_range(0, 1) == 1) begin
        rx = ax_m + int'($urandom_range(0, 24)) - 4;
        ry = ay_m + int'($urandom_range(0, 24)) - 4;
      end else begin
        rx = int'($urandom_range(0, 799));
        ry = int'($urandom_range(0, 524));
      end
      if (rx < 0) rx = 0;
      if (rx > 1023) rx = 1023;
      if (ry < 0) ry = 0;
      if (ry > 1023) ry = 1023;
      ft = ($urandom_range(0, 29) == 0);
      pv = ($urandom_range(0, 9) == 0);
      tick(rx, ry, (rx < 640) && (ry < 480), 1'($urandom), 1'($urandom), 12'($urandom),
           ft, pv, int'($urandom_range(0, 650)), int'($urandom_range(0, 490)), 1'b0, z);
    end

    // Reset pulse mid-line drops the pending position and clears everything.
    px(0, 0, 1'b0, 12'h444, 1'b1);
    offer(300, 300);
    px(300, 300, 1'b1, 12'h444, 1'b0);
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    check_outs("mid_reset", z);
    px(0, 0, 1'b0, 12'h444, 1'b1);
    px(300, 300, 1'b1, 12'h444, 1'b0);
    px(0, 0, 1'b1, 12'h444, 1'b0);
    chk("pending_dropped", 32'(hit), 32'(0));
    px(5, 5, 1'b0, 12'h444, 1'b0);
    chk("active_reset_pos", 32'(rgb), 32'(12'h00F));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
